// File: rtl/char_rom_status_if.sv
// Bundle between the game logic and the status text ROM: grid read port,
// level/score sources with the update request, and conversion status.
interface char_rom_status_if #(
    parameter int COLS    = 16,
    parameter int ROWS    = 16,
    parameter int LEVEL_W = 4,
    parameter int SCORE_W = 16
);
    localparam int XY_W = $clog2(ROWS) + $clog2(COLS);

    logic [XY_W-1:0]    char_xy;
    logic [LEVEL_W-1:0] level;
    logic [SCORE_W-1:0] score;
    logic               update;
    logic [6:0]         char_code;
    logic               busy;
    logic               done;

    modport master (
        output char_xy, level, score, update,
        input  char_code, busy, done
    );

    modport slave (
        input  char_xy, level, score, update,
        output char_code, busy, done
    );
endinterface

// File: rtl/char_rom_status.sv
// Status text ROM: "Level " / "Score " labels with decimal fields fed by a
// sequential double-dabble engine. Define CHAR_ROM_STATUS_LZB_EN for leading-zero blanking.
module char_rom_status #(
    parameter int COLS         = 16,
    parameter int ROWS         = 16,
    parameter int LEVEL_W      = 4,
    parameter int LEVEL_DIGITS = 2,
    parameter int SCORE_W      = 16,
    parameter int SCORE_DIGITS = 5
) (
    input  logic             pclk,
    input  logic             rst,
    char_rom_status_if.slave bus
);
    localparam int N         = (LEVEL_W > SCORE_W) ? LEVEL_W : SCORE_W;
    localparam int CNT_W     = $clog2(N + 1);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int COL_W     = $clog2(COLS);
    localparam int LBCD_W    = 4 * LEVEL_DIGITS;
    localparam int SBCD_W    = 4 * SCORE_DIGITS;
    localparam int LABEL_LEN = 6;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
    localparam logic [ROW_W-1:0] ROW_LEVEL = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_SCORE = ROW_W'(1);

    function automatic logic [31:0] dec_max(input int digits);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < digits; i++) v = v * 32'd10;
        return v - 32'd1;
    endfunction

    localparam logic [31:0] LEVEL_MAX = dec_max(LEVEL_DIGITS);
    localparam logic [31:0] SCORE_MAX = dec_max(SCORE_DIGITS);

    function automatic logic [3:0] dabble_nib(input logic [3:0] nib);
        logic [3:0] r;
        if (nib >= 4'd5) r = nib + 4'd3;
        else             r = nib;
        return r;
    endfunction

    function automatic logic [6:0] label_char(input logic is_score, input logic [2:0] idx);
        logic [6:0] c;
        case ({is_score, idx})
            4'b0_000: c = 7'h4C;
            4'b0_001: c = 7'h65;
            4'b0_010: c = 7'h76;
            4'b0_011: c = 7'h65;
            4'b0_100: c = 7'h6C;
            4'b1_000: c = 7'h53;
            4'b1_001: c = 7'h63;
            4'b1_010: c = 7'h6F;
            4'b1_011: c = 7'h72;
            4'b1_100: c = 7'h65;
            default:  c = 7'h20;
        endcase
        return c;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_pend, w_pend_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               w_capture, w_shift, w_load;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_lvl_sh, r_scr_sh;
    logic               r_lvl_sat, r_scr_sat;
    logic [LBCD_W-1:0]  r_lvl_bcd, w_lvl_adj, w_lvl_bcd_nxt, r_lvl_disp;
    logic [SBCD_W-1:0]  r_scr_bcd, w_scr_adj, w_scr_bcd_nxt, r_scr_disp;
    logic [LEVEL_DIGITS-1:0] w_lvl_blank;
    logic [SCORE_DIGITS-1:0] w_scr_blank;
    logic [ROW_W-1:0]   w_row_bits;
    logic [COL_W-1:0]   w_col_bits;
    int                 w_col, w_lvl_idx, w_scr_idx;
    logic [3:0]         w_lvl_nib, w_scr_nib;
    logic               w_lvl_blk, w_scr_blk;
    logic [6:0]         w_code, r_char_code;

    // Control state, pending flag and registered status outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state decode; digits are loaded on the CONV->COMMIT edge so they are visible while done is high.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.update) begin
                    w_capture   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_CONV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONV: begin
                w_shift = 1'b1;
                if (bus.update) w_pend_nxt = 1'b1;
                else            w_pend_nxt = r_pend;
                if (r_cnt == CNT_LAST) begin
                    w_load      = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_COMMIT: begin
                w_pend_nxt = 1'b0;
                if (r_pend || bus.update) begin
                    w_capture   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_CONV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_pend_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One double-dabble step per field: add-3 on every nibble >= 5, then shift the next bit in.
    always_comb begin
        w_lvl_adj = r_lvl_bcd;
        w_scr_adj = r_scr_bcd;
        for (int k = 0; k < LEVEL_DIGITS; k++) w_lvl_adj[k*4 +: 4] = dabble_nib(r_lvl_bcd[k*4 +: 4]);
        for (int k = 0; k < SCORE_DIGITS; k++) w_scr_adj[k*4 +: 4] = dabble_nib(r_scr_bcd[k*4 +: 4]);
        w_lvl_bcd_nxt = LBCD_W'({w_lvl_adj, r_lvl_sh[N-1]});
        w_scr_bcd_nxt = SBCD_W'({w_scr_adj, r_scr_sh[N-1]});
    end

    // Conversion datapath and display registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_lvl_sh   <= '0;
            r_scr_sh   <= '0;
            r_lvl_sat  <= 1'b0;
            r_scr_sat  <= 1'b0;
            r_lvl_bcd  <= '0;
            r_scr_bcd  <= '0;
            r_lvl_disp <= '0;
            r_scr_disp <= '0;
        end else begin
            if (w_capture) begin
                r_cnt     <= '0;
                r_lvl_sh  <= N'(bus.level);
                r_scr_sh  <= N'(bus.score);
                r_lvl_sat <= (32'(bus.level) > LEVEL_MAX);
                r_scr_sat <= (32'(bus.score) > SCORE_MAX);
                r_lvl_bcd <= '0;
                r_scr_bcd <= '0;
            end else if (w_shift) begin
                r_cnt     <= r_cnt + CNT_W'(1);
                r_lvl_sh  <= {r_lvl_sh[N-2:0], 1'b0};
                r_scr_sh  <= {r_scr_sh[N-2:0], 1'b0};
                r_lvl_bcd <= w_lvl_bcd_nxt;
                r_scr_bcd <= w_scr_bcd_nxt;
            end
            if (w_load) begin
                r_lvl_disp <= r_lvl_sat ? {LEVEL_DIGITS{4'h9}} : w_lvl_bcd_nxt;
                r_scr_disp <= r_scr_sat ? {SCORE_DIGITS{4'h9}} : w_scr_bcd_nxt;
            end
        end
    end

`ifdef CHAR_ROM_STATUS_LZB_EN
    // Zero digits above the first non-zero one are blanked; the units digit never is.
    always_comb begin
        logic seen_l, seen_s;
        w_lvl_blank = '0;
        w_scr_blank = '0;
        seen_l      = 1'b0;
        seen_s      = 1'b0;
        for (int k = LEVEL_DIGITS - 1; k > 0; k--) begin
            seen_l         = seen_l | (r_lvl_disp[k*4 +: 4] != 4'h0);
            w_lvl_blank[k] = ~seen_l;
        end
        for (int k = SCORE_DIGITS - 1; k > 0; k--) begin
            seen_s         = seen_s | (r_scr_disp[k*4 +: 4] != 4'h0);
            w_scr_blank[k] = ~seen_s;
        end
    end
`else
    assign w_lvl_blank = '0;
    assign w_scr_blank = '0;
`endif

    assign w_row_bits = bus.char_xy[ROW_W+COL_W-1:COL_W];
    assign w_col_bits = bus.char_xy[COL_W-1:0];
    assign w_col      = int'(w_col_bits);
    assign w_lvl_idx  = LEVEL_DIGITS - 1 - (w_col - LABEL_LEN);
    assign w_scr_idx  = SCORE_DIGITS - 1 - (w_col - LABEL_LEN);
    assign w_lvl_nib  = 4'(r_lvl_disp >> (4 * w_lvl_idx));
    assign w_scr_nib  = 4'(r_scr_disp >> (4 * w_scr_idx));
    assign w_lvl_blk  = 1'(w_lvl_blank >> w_lvl_idx);
    assign w_scr_blk  = 1'(w_scr_blank >> w_scr_idx);

    // Grid address to character map; digit columns run MSD first.
    always_comb begin
        w_code = 7'h20;
        if (w_row_bits == ROW_LEVEL) begin
            if (w_col < LABEL_LEN)                          w_code = label_char(1'b0, w_col_bits[2:0]);
            else if (w_col < LABEL_LEN + LEVEL_DIGITS)      w_code = w_lvl_blk ? 7'h20 : {3'b011, w_lvl_nib};
            else                                            w_code = 7'h20;
        end else if (w_row_bits == ROW_SCORE) begin
            if (w_col < LABEL_LEN)                          w_code = label_char(1'b1, w_col_bits[2:0]);
            else if (w_col < LABEL_LEN + SCORE_DIGITS)      w_code = w_scr_blk ? 7'h20 : {3'b011, w_scr_nib};
            else                                            w_code = 7'h20;
        end else begin
            w_code = 7'h20;
        end
    end

    // Registered read port.
    always_ff @(posedge pclk) begin
        if (rst) r_char_code <= 7'h20;
        else     r_char_code <= w_code;
    end

    assign bus.char_code = r_char_code;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
